// File: rtl/imem_loader.sv
// Byte-serial instruction store loader; gates the core via cpu_run.
// Optional IMEM_CHECKSUM_EN: image must sum to 0x00 mod 256 to run.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic [ADDR_W-1:0] PC,
  output logic [7:0]        INST,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              cpu_run,
  output logic              ld_err
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic [7:0]        chk_sum
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [1:0]        nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              beat;
  logic              sum_ok;
  logic [7:0]        mem [DEPTH];

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] sum_nxt;
  always_comb begin
    sum_nxt = chk_sum + ld_data;
    sum_ok  = (sum_nxt == 8'h00);
  end
`else
  assign sum_ok = 1'b1;
`endif

  assign ld_ready = (state == S_LOAD);
  // A restart wins over any coincident beat.
  assign beat = ld_ready & ld_valid & ~ld_start;

  always_comb begin
    nxt = state;
    if (ld_start) begin
      nxt = S_LOAD;
    end else if (beat) begin
      if (ld_last)
        nxt = sum_ok ? S_RUN : S_ERR;
      else if (wr_ptr == LAST_ADDR)
        nxt = S_ERR;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLB) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      ld_count <= '0;
      cpu_run  <= 1'b0;
      ld_err   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      chk_sum  <= 8'h00;
`endif
    end else begin
      state   <= nxt;
      cpu_run <= (nxt == S_RUN);
      if (ld_start) begin
        wr_ptr   <= '0;
        ld_count <= '0;
        ld_err   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
        chk_sum  <= 8'h00;
`endif
      end else if (beat) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (ld_count != FULL_CNT)
          ld_count <= ld_count + 1'b1;
        if (nxt == S_ERR)
          ld_err <= 1'b1;
`ifdef IMEM_CHECKSUM_EN
        chk_sum <= sum_nxt;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (beat)
      mem[wr_ptr] <= ld_data;
  end

  // Bytes past the loaded image read as zero even if stale data remains.
  always_comb begin
    INST = 8'h00;
    if (state == S_RUN && {1'b0, PC} < ld_count)
      INST = mem[PC];
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; runs in default and
// IMEM_CHECKSUM_EN builds (image tails adjusted to sum to zero).
module tb_imem_loader;

  logic       CLK = 1'b0;
  logic       CLB = 1'b1;
  logic [7:0] PC = '0;
  logic [7:0] INST;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_last = 1'b0;
  logic       ld_ready;
  logic [8:0] ld_count;
  logic       cpu_run;
  logic       ld_err;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0] chk_sum;
  localparam logic [7:0] T1 = 8'hCD;
  localparam logic [7:0] T3 = 8'hBD;
  localparam logic [7:0] T4 = 8'h00;
`else
  localparam logic [7:0] T1 = 8'h33;
  localparam logic [7:0] T3 = 8'hA3;
  localparam logic [7:0] T4 = 8'h55;
`endif

  int n_chk = 0;
  int n_err = 0;

  imem_loader dut (
    .CLK(CLK),
    .CLB(CLB),
    .PC(PC),
    .INST(INST),
    .ld_start(ld_start),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .ld_ready(ld_ready),
    .ld_count(ld_count),
    .cpu_run(cpu_run),
    .ld_err(ld_err)
`ifdef IMEM_CHECKSUM_EN
    ,
    .chk_sum(chk_sum)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [7:0] a,
                    input logic [7:0] exp);
    PC = a;
    #1;
    check(tag, INST, exp);
  endtask

  initial begin
    tick();
    tick();
    CLB = 1'b0;
    check("rst_cnt", ld_count, 0);
    check("rst_run", cpu_run, 0);
    check("rst_err", ld_err, 0);
    check("rst_rdy", ld_ready, 0);
    rd("rst_inst", 8'd0, 8'h00);

    // basic 3-byte image
    start();
    check("ld_rdy", ld_ready, 1);
    beat(8'h11, 1'b0);
    rd("ld_inst0", 8'd0, 8'h00);
    beat(8'h22, 1'b0);
    beat(T1, 1'b1);
    check("b_cnt", ld_count, 3);
    check("b_run", cpu_run, 1);
    check("b_rdy", ld_ready, 0);
    rd("b_pc0", 8'd0, 8'h11);
    rd("b_pc1", 8'd1, 8'h22);
    rd("b_pc2", 8'd2, T1);
    rd("b_pc3", 8'd3, 8'h00);
    rd("b_pc5", 8'd5, 8'h00);

    // reload from RUN, valid toggling
    start();
    check("rl_run", cpu_run, 0);
    check("rl_cnt", ld_count, 0);
    check("rl_rdy", ld_ready, 1);
    beat(8'hA1, 1'b0);
    tick();
    beat(8'hA2, 1'b0);
    tick();
    check("tg_cnt", ld_count, 2);
    beat(T3, 1'b1);
    check("tg_cnt3", ld_count, 3);
    check("tg_run", cpu_run, 1);
    rd("tg_pc0", 8'd0, 8'hA1);
    rd("tg_pc1", 8'd1, 8'hA2);
    rd("tg_pc2", 8'd2, T3);

    // restart with coincident beat
    start();
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 8'hAA;
    start();
    ld_valid = 1'b0;
    check("rs_cnt", ld_count, 0);
    check("rs_rdy", ld_ready, 1);
    beat(T4, 1'b1);
    check("rs_cnt1", ld_count, 1);
    check("rs_run", cpu_run, 1);
    rd("rs_pc0", 8'd0, T4);
    rd("rs_pc1", 8'd1, 8'h00);

    // overflow
    start();
    for (int i = 0; i < 256; i++)
      beat(8'(i + 1), 1'b0);
    check("ov_err", ld_err, 1);
    check("ov_run", cpu_run, 0);
    check("ov_rdy", ld_ready, 0);
    check("ov_cnt", ld_count, 256);
    rd("ov_inst", 8'd0, 8'h00);
    tick();
    check("ov_stk", ld_err, 1);
    start();
    check("ov_clr", ld_err, 0);
    beat(8'h00, 1'b1);
    check("ov_run2", cpu_run, 1);
    check("ov_cnt1", ld_count, 1);

    // reset mid-load
    start();
    beat(8'h31, 1'b0);
    beat(8'h32, 1'b0);
    CLB = 1'b1;
    tick();
    CLB = 1'b0;
    check("mr_cnt", ld_count, 0);
    check("mr_run", cpu_run, 0);
    check("mr_rdy", ld_ready, 0);
    tick();
    check("mr_idle", ld_ready, 0);

`ifdef IMEM_CHECKSUM_EN
    start();
    beat(8'h10, 1'b0);
    beat(8'h20, 1'b0);
    check("ck_part", chk_sum, 8'h30);
    beat(8'hD0, 1'b1);
    check("ck_run", cpu_run, 1);
    check("ck_sum0", chk_sum, 8'h00);
    rd("ck_pc2", 8'd2, 8'hD0);
    start();
    beat(8'h10, 1'b0);
    beat(8'h20, 1'b0);
    beat(8'hD1, 1'b1);
    check("ck_err", ld_err, 1);
    check("ck_nrun", cpu_run, 0);
    check("ck_sum1", chk_sum, 8'h01);
    check("ck_rdy", ld_ready, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program-memory stage sitting directly upstream of the processor core.
- Holds a DEPTH x 8 instruction store, loaded byte-serially over a valid/ready load port.
- Serves INST combinationally from the core's PC address bus.
- Gates core execution through cpu_run; top level drives the core's CLB from cpu_run, so the core runs only once a complete image is present.

Parameters:
DEPTH, 256, number of instruction bytes; must equal 2**ADDR_W
ADDR_W, 8, address width; matches PC width

Ports:
CLK  input  1  system clock, all state updates on rising edge
CLB  input  1  reset, synchronous, active-high
PC  input  ADDR_W  instruction address from core
INST  output  8  instruction byte to core
ld_start  input  1  one-cycle pulse: begin (or restart) an image load
ld_valid  input  1  ld_data carries a byte
ld_data  input  8  image byte
ld_last  input  1  qualifies final byte of image (sampled with ld_valid)
ld_ready  output  1  loader accepts a byte this cycle
ld_count  output  ADDR_W+1  bytes written in current or last load
cpu_run  output  1  1 = core may execute; 0 = hold core in reset
ld_err  output  1  sticky error flag for last load attempt

Behaviour:
- Reset (CLB=1 at edge): state=IDLE, wr_ptr=0, ld_count=0, cpu_run=0, ld_err=0. Memory array not cleared.
- States: IDLE, LOAD, RUN, ERR. Encoding free.
- ld_ready = (state==LOAD), combinational from state.
- cpu_run = (state==RUN), registered.
- IDLE:
  - ld_start -> LOAD; wr_ptr=0, ld_count=0, ld_err=0.
- LOAD:
  - Beat = ld_valid & ld_ready; writes mem[wr_ptr]<=ld_data, wr_ptr++, ld_count++.
  - Beat with ld_last=1 -> RUN. cpu_run high from the cycle after the last-beat edge.
  - Beat at wr_ptr==DEPTH-1 with ld_last=0 -> ERR with ld_err=1 (overflow). The byte is still written; ld_count=DEPTH.
  - ld_start while in LOAD: restart. wr_ptr=0, ld_count=0; a coincident beat is discarded (ld_start has priority).
  - ld_valid=0: hold, no write.
- RUN:
  - INST = mem[PC] if PC < ld_count, else 0x00. Zero latency, combinational read.
  - ld_start -> LOAD. cpu_run drops at that same edge; reload proceeds as above.
  - ld_valid ignored.
- ERR:
  - cpu_run=0, ld_ready=0.
  - Only ld_start (-> LOAD, clears ld_err) or reset leave ERR.
- INST = 0x00 whenever state != RUN.
- ld_count saturates at DEPTH and never wraps. wr_ptr wraps only via restart or reset.
- Reset mid-load: load aborted, state IDLE. Partially written bytes remain in memory but are unreachable because ld_count=0.
- Empty image is impossible: the first beat with ld_last=1 gives ld_count=1.

Optional Feature:
IMEM_CHECKSUM_EN
- Defined:
  - Loader keeps an 8-bit modulo-256 sum of every accepted byte, including the last.
  - Sum clears on ld_start.
  - On the last beat: if the final sum is 0x00, go to RUN; otherwise go to ERR with ld_err=1.
  - The checksum byte is the last byte of the image and is stored like any other.
  - Extra output port chk_sum[7:0] shows the running sum.
- Undefined:
  - No sum logic and no chk_sum port.
  - The last beat always enters RUN.

Test Plan:
- Reset, ld_start, beats 0x11,0x22,0x33(last) -> ld_count=3, cpu_run=1 next cycle; PC=1 -> INST=0x22; PC=5 -> INST=0x00.
- ld_valid toggled 1,0,1,0 during LOAD -> only valid cycles written, addresses contiguous, ld_count=2 after two beats.
- 256 beats with no ld_last -> ld_err=1, state ERR, cpu_run=0, INST=0x00; then ld_start plus 1 beat(last) -> ld_err=0, cpu_run=1.
- ld_start asserted together with a beat of 0xAA mid-load -> beat discarded, ld_count=0; next beat 0x55(last) lands at address 0.
- CLB=1 in cycle after the 2nd of 4 beats -> ld_count=0, cpu_run=0, ld_ready=0; ld_start in RUN -> cpu_run=0 same edge.
- IMEM_CHECKSUM_EN: bytes 0x10,0x20,0xD0(last) -> RUN. Bytes 0x10,0x20,0xD1(last) -> ERR, chk_sum=0x01.
